// File: rtl/ext_unit.sv
// Extends immediates (SEXT/ZEXT/LUI) and load data (LB/LBU/LH/LHU/WORD), flagging misaligned loads.
// Latency: one cycle from accept to out_* when the output register is free; one result per cycle sustained.
// Backpressure: 2-entry skid buffer; in_ready is registered (!skid.valid), so out_ready has no combinational path to in_ready.
module ext_unit #(
    parameter int  DATA_W = 32,
    parameter int  IMM_W  = 16,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  addr_off,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    typedef enum logic [2:0] {
        OP_SEXT = 3'd0,
        OP_ZEXT = 3'd1,
        OP_LUI  = 3'd2,
        OP_LB   = 3'd3,
        OP_LBU  = 3'd4,
        OP_LH   = 3'd5,
        OP_LHU  = 3'd6,
        OP_WORD = 3'd7
    } ext_op_e;

    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] sext_v;
    logic [DATA_W-1:0] zext_v;
    logic [DATA_W-1:0] lui_v;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext_dat;
    logic              ext_err;

    // Output register (O) and skid register (S) state.
    logic              o_vld_q, o_vld_d;
    logic [DATA_W-1:0] o_dat_q, o_dat_d;
    logic              o_err_q, o_err_d;
    logic              s_vld_q, s_vld_d;
    logic [DATA_W-1:0] s_dat_q, s_dat_d;
    logic              s_err_q, s_err_d;

    logic accept;
    logic drain;

    // Extension datapath: the only combinational logic between inputs and the registers.
    always_comb begin
        imm     = data[IMM_W-1:0];
        sext_v  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        zext_v  = {{(DATA_W-IMM_W){1'b0}}, imm};
        // Shifting the sign-extended immediate places it at [2*IMM_W-1:IMM_W]
        // and leaves sign fill above it for widths wider than 2*IMM_W.
        lui_v   = sext_v << IMM_W;
        // Bring the addressed byte/halfword down to bit 0.
        shifted = data >> {addr_off, 3'b000};
        ext_dat = '0;
        ext_err = 1'b0;
        case (op)
            OP_SEXT: ext_dat = sext_v;
            OP_ZEXT: ext_dat = zext_v;
            OP_LUI:  ext_dat = lui_v;
            OP_LB:   ext_dat = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            OP_LBU:  ext_dat = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            OP_LH: begin
                if (addr_off[0]) ext_err = 1'b1;
                else             ext_dat = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            end
            OP_LHU: begin
                if (addr_off[0]) ext_err = 1'b1;
                else             ext_dat = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            end
            OP_WORD: begin
                if (addr_off != '0) ext_err = 1'b1;
                else                ext_dat = data;
            end
            default: ext_dat = '0;
        endcase
    end

    assign in_ready  = !s_vld_q;
    assign out_valid = o_vld_q;
    assign out_data  = o_dat_q;
    assign out_err   = o_err_q;

    assign accept = in_valid && !s_vld_q;
    assign drain  = o_vld_q && out_ready;

    // Skid-buffer next state: flush wins, then drain (S->O or direct reload), then fill.
    always_comb begin
        o_vld_d = o_vld_q;
        o_dat_d = o_dat_q;
        o_err_d = o_err_q;
        s_vld_d = s_vld_q;
        s_dat_d = s_dat_q;
        s_err_d = s_err_q;
        if (flush) begin
            o_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (drain) begin
            if (s_vld_q) begin
                // No accept is possible here: in_ready is low while S is full.
                o_vld_d = 1'b1;
                o_dat_d = s_dat_q;
                o_err_d = s_err_q;
                s_vld_d = 1'b0;
            end else if (accept) begin
                o_vld_d = 1'b1;
                o_dat_d = ext_dat;
                o_err_d = ext_err;
            end else begin
                o_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!o_vld_q) begin
                o_vld_d = 1'b1;
                o_dat_d = ext_dat;
                o_err_d = ext_err;
            end else begin
                s_vld_d = 1'b1;
                s_dat_d = ext_dat;
                s_err_d = ext_err;
            end
        end
    end

    // State registers; reset empties both entries and zeroes the visible outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_vld_q <= 1'b0;
            o_dat_q <= '0;
            o_err_q <= 1'b0;
            s_vld_q <= 1'b0;
            s_dat_q <= '0;
            s_err_q <= 1'b0;
        end else begin
            o_vld_q <= o_vld_d;
            o_dat_q <= o_dat_d;
            o_err_q <= o_err_d;
            s_vld_q <= s_vld_d;
            s_dat_q <= s_dat_d;
            s_err_q <= s_err_d;
        end
    end

endmodule
